mul_div_sequencer: RTL and testbench

- Multi-cycle signed multiply/divide unit with its own sequencing FSM.
- Owned by the Processor control unit; executes MUL and DIV and writes the 64-bit HI/LO result pair that MFHI/MFLO later read.
- Handshake is start/busy/done, so the control FSM stalls on oBusy instead of waiting a fixed cycle count.
- Replaces the single-cycle combinational multiplier and divider path.

---
 rtl/mul_div_sequencer_if.sv | 27 ++
 rtl/mul_div_sequencer.sv | 179 +++++++++++++++++
 tb/tb_mul_div_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mul_div_sequencer_if.sv
// Request/response bundle between the processor control FSM (master) and the
// multiply/divide sequencer (slave). iStart is sampled only while the sequencer is idle.
interface mul_div_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  iStart;
  logic                  iOp;
  logic                  iFlush;
  logic [DATA_WIDTH-1:0] iA;
  logic [DATA_WIDTH-1:0] iB;
  logic                  oBusy;
  logic                  oDone;
  logic                  oDivZero;
  logic [DATA_WIDTH-1:0] oHI;
  logic [DATA_WIDTH-1:0] oLO;
  logic [2:0]            oDbgState;

  modport master (
    output iStart, iOp, iFlush, iA, iB,
    input  oBusy, oDone, oDivZero, oHI, oLO, oDbgState
  );

  modport slave (
    input  iStart, iOp, iFlush, iA, iB,
    output oBusy, oDone, oDivZero, oHI, oLO, oDbgState
  );
endinterface

// File: rtl/mul_div_sequencer.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit producing HI/LO.
// Handshake: iStart accepted in IDLE; oBusy/oDone are registered and trail the FSM by one cycle.
module mul_div_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                iClk,
  input  logic                nRst,
  mul_div_sequencer_if.slave  bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL_RUN = 3'd1,
    S_DIV_RUN = 3'd2,
    S_DIV_FIX = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W:0]           acc_q, acc_d;     // Booth partial product / division remainder
  logic [W-1:0]         qr_q, qr_d;       // multiplier shift register / quotient
  logic [W-1:0]         m_q, m_d;         // multiplicand / divisor magnitude
  logic                 bit_q, bit_d;     // Booth q(-1)
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic                 dz_q, dz_d;
  logic [W-1:0]         hi_q, lo_q;
  logic                 dz_out_q, done_q, busy_q;
  logic                 done_set, busy_set;

  logic [W:0]   msx, booth_sum, shifted;
  logic [W+1:0] diff;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? -x : x;
  endfunction

  // State register
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides every busy transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          if (!bus.iOp)         state_d = S_MUL_RUN;
          else if (bus.iB == '0) state_d = S_DONE;
          else                  state_d = S_DIV_RUN;
        end
      end
      S_MUL_RUN: if (cnt_q == LAST) state_d = S_DONE;
      S_DIV_RUN: if (cnt_q == LAST) state_d = S_DIV_FIX;
      S_DIV_FIX: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (bus.iFlush && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Output decode
  always_comb begin
    done_set      = (state_q == S_DONE) && !bus.iFlush;
    busy_set      = (state_q != S_IDLE);
    bus.oBusy     = busy_q;
    bus.oDone     = done_q;
    bus.oDivZero  = dz_out_q;
    bus.oHI       = hi_q;
    bus.oLO       = lo_q;
    bus.oDbgState = state_q;
  end

  // Datapath next-state
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    qr_d  = qr_q;
    m_d   = m_q;
    bit_d = bit_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    dz_d  = dz_q;
    msx       = {m_q[W-1], m_q};
    booth_sum = acc_q;
    shifted   = {acc_q[W-1:0], qr_q[W-1]};
    diff      = {1'b0, shifted} - {2'b00, m_q};
    unique case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          cnt_d = '0;
          bit_d = 1'b0;
          sa_d  = bus.iA[W-1];
          sb_d  = bus.iB[W-1];
          dz_d  = 1'b0;
          acc_d = '0;
          if (!bus.iOp) begin
            qr_d = bus.iA;
            m_d  = bus.iB;
          end else if (bus.iB == '0) begin
            acc_d = {bus.iA[W-1], bus.iA};
            qr_d  = '1;
            m_d   = '0;
            dz_d  = 1'b1;
          end else begin
            qr_d = mag(bus.iA);
            m_d  = mag(bus.iB);
          end
        end
      end
      S_MUL_RUN: begin
        // Partial product carries one extra bit so -2^(W-1) multiplicands don't overflow
        unique case ({qr_q[0], bit_q})
          2'b01:   booth_sum = acc_q + msx;
          2'b10:   booth_sum = acc_q - msx;
          default: booth_sum = acc_q;
        endcase
        acc_d = {booth_sum[W], booth_sum[W:1]};
        qr_d  = {booth_sum[0], qr_q[W-1:1]};
        bit_d = qr_q[0];
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      S_DIV_RUN: begin
        if (!diff[W+1]) begin
          acc_d = diff[W:0];
          qr_d  = {qr_q[W-2:0], 1'b1};
        end else begin
          acc_d = shifted;
          qr_d  = {qr_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      S_DIV_FIX: begin
        qr_d  = (sa_q ^ sb_q) ? -qr_q : qr_q;
        acc_d = sa_q ? {1'b0, -acc_q[W-1:0]} : acc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      qr_q     <= '0;
      m_q      <= '0;
      bit_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_out_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      qr_q   <= qr_d;
      m_q    <= m_d;
      bit_q  <= bit_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      dz_q   <= dz_d;
      done_q <= done_set;
      busy_q <= busy_set;
      if (done_set) begin
        hi_q     <= acc_q[W-1:0];
        lo_q     <= qr_q;
        dz_out_q <= dz_q;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed and random checks of the multiply/divide sequencer: latency, results,
// divide-by-zero, flush, ignored restarts and asynchronous reset.
module tb_mul_div_sequencer;
  logic clk;
  logic nRst;
  int   tests;
  int   fails;
  logic [64:0] exp_q[$];

  mul_div_sequencer_if #(.DATA_WIDTH(32)) bus ();

  mul_div_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .iClk (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; the next edge is the start edge (edge 0)
  task automatic do_op(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input logic exp_dz,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [64:0] exp;
    int lat;
    logic busy_ok;
    exp_q.push_back({exp_dz, exp_hi, exp_lo});
    bus.iOp = op; bus.iA = a; bus.iB = b; bus.iStart = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0; bus.iA = $urandom; bus.iB = $urandom;
    lat = 0; busy_ok = 1'b1;
    while (!bus.oDone && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!bus.oBusy) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    exp = exp_q.pop_front();
    chk({tag, "_hi"}, 64'(bus.oHI), 64'(exp[63:32]));
    chk({tag, "_lo"}, 64'(bus.oLO), 64'(exp[31:0]));
    chk({tag, "_divzero"}, 64'(bus.oDivZero), 64'(exp[64]));
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, 64'(bus.oDone), 64'd0);
    chk({tag, "_busy_drop"}, 64'(bus.oBusy), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    longint p, qq, rr;
    int done_seen;
    tests = 0; fails = 0;
    bus.iStart = 0; bus.iOp = 0; bus.iFlush = 0; bus.iA = '0; bus.iB = '0;
    nRst = 1'b0;
    repeat (3) @(posedge clk);
    #1 nRst = 1'b1;
    chk("reset_busy", 64'(bus.oBusy), 64'd0);
    chk("reset_done", 64'(bus.oDone), 64'd0);
    chk("reset_hi", 64'(bus.oHI), 64'd0);
    chk("reset_lo", 64'(bus.oLO), 64'd0);
    chk("reset_state", 64'(bus.oDbgState), 64'd0);
    @(posedge clk); #1;

    do_op("mul_10x5", 1'b0, 32'd10, 32'd5, 33, 1'b0, 32'h0, 32'h32);
    do_op("mul_m7x3", 1'b0, -32'sd7, 32'd3, 33, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
    do_op("mul_min2", 1'b0, 32'h80000000, 32'h80000000, 33, 1'b0, 32'h40000000, 32'h0);
    do_op("div_17_m5", 1'b1, 32'd17, -32'sd5, 34, 1'b0, 32'h2, 32'hFFFFFFFD);
    do_op("div_m17_5", 1'b1, -32'sd17, 32'd5, 34, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFD);
    do_op("div_9_0", 1'b1, 32'd9, 32'd0, 1, 1'b1, 32'd9, 32'hFFFFFFFF);
    do_op("mul_2x2", 1'b0, 32'd2, 32'd2, 33, 1'b0, 32'h0, 32'd4);

    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      p = longint'($signed(a)) * longint'($signed(b));
      do_op("mul_rand", 1'b0, a, b, 33, 1'b0, p[63:32], p[31:0]);
    end
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = 32'($urandom_range(1, 70000));
      if (i[0]) b = -b;
      qq = longint'($signed(a)) / longint'($signed(b));
      rr = longint'($signed(a)) % longint'($signed(b));
      do_op("div_rand", 1'b1, a, b, 34, 1'b0, rr[31:0], qq[31:0]);
    end

    do_op("mul_3x3", 1'b0, 32'd3, 32'd3, 33, 1'b0, 32'h0, 32'd9);
    // MUL 6x7 with an ignored restart at edge 5 and a flush at edge 10
    bus.iOp = 1'b0; bus.iA = 32'd6; bus.iB = 32'd7; bus.iStart = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    done_seen = 0;
    for (int e = 1; e <= 45; e++) begin
      if (e == 4) begin bus.iStart = 1'b1; bus.iOp = 1'b1; bus.iA = 32'd100; bus.iB = 32'd3; end
      if (e == 5) bus.iStart = 1'b0;
      if (e == 9) bus.iFlush = 1'b1;
      @(posedge clk); #1;
      if (e == 10) begin
        bus.iFlush = 1'b0;
        chk("flush_state_idle", 64'(bus.oDbgState), 64'd0);
      end
      if (e == 11) chk("flush_busy_low", 64'(bus.oBusy), 64'd0);
      if (bus.oDone) done_seen++;
    end
    chk("flush_no_done", 64'(done_seen), 64'd0);
    chk("flush_lo_hold", 64'(bus.oLO), 64'd9);
    do_op("mul_6x7", 1'b0, 32'd6, 32'd7, 33, 1'b0, 32'h0, 32'd42);

    // Asynchronous reset during DIV_RUN
    bus.iOp = 1'b1; bus.iA = 32'd1000; bus.iB = 32'd7; bus.iStart = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    repeat (19) @(posedge clk);
    #2 nRst = 1'b0;
    #1;
    chk("rst_busy", 64'(bus.oBusy), 64'd0);
    chk("rst_hi", 64'(bus.oHI), 64'd0);
    chk("rst_lo", 64'(bus.oLO), 64'd0);
    chk("rst_state", 64'(bus.oDbgState), 64'd0);
    #1 nRst = 1'b1;
    done_seen = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (bus.oDone) done_seen++;
    end
    chk("rst_no_done", 64'(done_seen), 64'd0);
    do_op("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 34, 1'b0, 32'h0, 32'h80000000);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
